operand_skid_stage: RTL and testbench

Registered pipeline stage that carries a four-operand bundle (`d0`–`d3` plus a 2-bit select) from decode into the execute-side 4:1 operand multiplexer. Its outputs wire directly to that mux's data and select inputs. It decouples the two stages with a valid/ready handshake and a 2-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`. It also supports a pipeline flush for branch redirect.

---
 rtl/operand_skid_stage.sv | 118 +++++++++++
 tb/tb_operand_skid_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_skid_stage.sv
// operand_skid_stage: registered decode-to-execute operand bundle stage.
// Valid/ready handshake with a two-entry skid buffer and branch flush.
module operand_skid_stage #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_d0,
  input  logic [N-1:0] in_d1,
  input  logic [N-1:0] in_d2,
  input  logic [N-1:0] in_d3,
  input  logic [1:0]   in_sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_d0,
  output logic [N-1:0] out_d1,
  output logic [N-1:0] out_d2,
  output logic [N-1:0] out_d3,
  output logic [1:0]   out_sel,
  output logic [1:0]   occupancy
);

  typedef struct packed {
    logic [N-1:0] d0;
    logic [N-1:0] d1;
    logic [N-1:0] d2;
    logic [N-1:0] d3;
    logic [1:0]   sel;
  } bundle_t;

  bundle_t in_b;
  bundle_t m_q;
  bundle_t s_q;
  bundle_t m_n;
  bundle_t s_n;
  logic    m_v;
  logic    s_v;
  logic    m_v_n;
  logic    s_v_n;
  logic    accept;
  logic    drain;

  assign in_b.d0  = in_d0;
  assign in_b.d1  = in_d1;
  assign in_b.d2  = in_d2;
  assign in_b.d3  = in_d3;
  assign in_b.sel = in_sel;

  // Ready only looks at the skid flag and flush, never at out_ready.
  assign in_ready  = ~s_v & ~flush;
  assign out_valid = m_v;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  assign out_d0    = m_q.d0;
  assign out_d1    = m_q.d1;
  assign out_d2    = m_q.d2;
  assign out_d3    = m_q.d3;
  assign out_sel   = m_q.sel;
  assign occupancy = {1'b0, m_v} + {1'b0, s_v};

  // Next-state for main/skid entries; data moves only on real transfers.
  always_comb begin
    m_n   = m_q;
    s_n   = s_q;
    m_v_n = m_v;
    s_v_n = s_v;
    if (flush) begin
      m_v_n = 1'b0;
      s_v_n = 1'b0;
    end else begin
      unique case (1'b1)
        drain & s_v: begin
          // skid full means in_ready is low, so nothing refills S
          m_n   = s_q;
          s_v_n = 1'b0;
        end
        drain & ~s_v: begin
          if (accept) m_n = in_b;
          m_v_n = accept;
        end
        ~drain & ~m_v: begin
          if (accept) m_n = in_b;
          m_v_n = accept;
        end
        ~drain & m_v & ~s_v: begin
          if (accept) s_n = in_b;
          s_v_n = accept;
        end
        ~drain & m_v & s_v: begin
          m_n = m_q;
        end
        default: begin
          m_n = m_q;
        end
      endcase
    end
  end

  // State registers; reset also zeroes data so the mux sees clean operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
      s_q <= '0;
      m_v <= 1'b0;
      s_v <= 1'b0;
    end else begin
      m_q <= m_n;
      s_q <= s_n;
      m_v <= m_v_n;
      s_v <= s_v_n;
    end
  end

endmodule

// File: tb/tb_operand_skid_stage.sv
// tb_operand_skid_stage: directed vector table plus an N=8 sequence.
// Inputs applied 1 after posedge; outputs sampled 1 after next posedge.
module tb_operand_skid_stage;

  typedef struct packed {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] d3;
    logic [1:0]  sel;
  } bnd_t;

  typedef struct packed {
    logic       rst;
    logic       fl;
    logic       iv;
    logic       ordy;
    bnd_t       in;
    logic       e_ir;
    logic       e_ov;
    logic [1:0] e_occ;
    bnd_t       ex;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_d0, in_d1, in_d2, in_d3;
  logic [1:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_d0, out_d1, out_d2, out_d3;
  logic [1:0]  out_sel;
  logic [1:0]  occupancy;

  logic        flush8;
  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  in8_d0, in8_d1, in8_d2, in8_d3;
  logic [1:0]  in8_sel;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  out8_d0, out8_d1, out8_d2, out8_d3;
  logic [1:0]  out8_sel;
  logic [1:0]  occupancy8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  operand_skid_stage #(.N(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2), .in_d3(in_d3),
    .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d0(out_d0), .out_d1(out_d1), .out_d2(out_d2), .out_d3(out_d3),
    .out_sel(out_sel), .occupancy(occupancy)
  );

  operand_skid_stage #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .flush(flush8),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_d0(in8_d0), .in_d1(in8_d1), .in_d2(in8_d2), .in_d3(in8_d3),
    .in_sel(in8_sel),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_d0(out8_d0), .out_d1(out8_d1), .out_d2(out8_d2), .out_d3(out8_d3),
    .out_sel(out8_sel), .occupancy(occupancy8)
  );

  task automatic chk(input string nm, input int row,
                     input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
  endtask

  function automatic bnd_t b(input logic [15:0] a0, input logic [15:0] a1,
                             input logic [15:0] a2, input logic [15:0] a3,
                             input logic [1:0] s);
    bnd_t r;
    r.d0 = a0; r.d1 = a1; r.d2 = a2; r.d3 = a3; r.sel = s;
    return r;
  endfunction

  function automatic vec_t mv(input logic rst, input logic fl,
                              input logic iv, input logic ordy,
                              input bnd_t i, input logic e_ir,
                              input logic e_ov, input logic [1:0] e_occ,
                              input bnd_t e);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.in = i;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_occ = e_occ; v.ex = e;
    return v;
  endfunction

  vec_t vecs[$];
  bnd_t Z, B1, B2, B3, A1, A2, A3, C1, C2, C3, C4, C5, D1, D2, E, F, G;

  initial begin
    Z  = b(16'h0, 16'h0, 16'h0, 16'h0, 2'd0);
    B1 = b(16'h0011, 16'h0101, 16'h0201, 16'h0301, 2'd0);
    B2 = b(16'h0022, 16'h0102, 16'h0202, 16'h0302, 2'd1);
    B3 = b(16'h0033, 16'h0103, 16'h0203, 16'h0303, 2'd2);
    A1 = b(16'h1001, 16'hA001, 16'h2001, 16'h3001, 2'd1);
    A2 = b(16'h1002, 16'hA002, 16'h2002, 16'h3002, 2'd2);
    A3 = b(16'h1003, 16'hA003, 16'h2003, 16'h3003, 2'd3);
    C1 = b(16'h4001, 16'h5001, 16'h6001, 16'h7001, 2'd1);
    C2 = b(16'h4002, 16'h5002, 16'h6002, 16'h7002, 2'd2);
    C3 = b(16'h4003, 16'h5003, 16'h6003, 16'h7003, 2'd3);
    C4 = b(16'h4004, 16'h5004, 16'h6004, 16'h7004, 2'd0);
    C5 = b(16'h4005, 16'h5005, 16'h6005, 16'h7005, 2'd1);
    D1 = b(16'h8001, 16'h8101, 16'h8201, 16'h8301, 2'd3);
    D2 = b(16'h8002, 16'h8102, 16'h8202, 16'h8302, 2'd0);
    E  = b(16'hEEEE, 16'hEEEE, 16'hEEEE, 16'hFFFF, 2'd1);
    F  = b(16'h9001, 16'h9101, 16'h9201, 16'h9301, 2'd3);
    G  = b(16'hB001, 16'hB101, 16'hB201, 16'hB301, 2'd2);

    //             rst fl iv ordy in   ir ov occ exp
    // stream three with out_ready high; no bypass on first
    vecs.push_back(mv(0, 0, 1, 0, B1, 1, 1, 1, B1));
    vecs.push_back(mv(0, 0, 1, 1, B2, 1, 1, 1, B2));
    vecs.push_back(mv(0, 0, 1, 1, B3, 1, 1, 1, B3));
    vecs.push_back(mv(0, 0, 0, 1, Z,  1, 0, 0, B3));
    // back-pressure: fill both entries, hold, then drain
    vecs.push_back(mv(0, 0, 1, 0, A1, 1, 1, 1, A1));
    vecs.push_back(mv(0, 0, 1, 0, A2, 1, 1, 2, A1));
    vecs.push_back(mv(0, 0, 1, 0, A3, 0, 1, 2, A1));
    vecs.push_back(mv(0, 0, 1, 0, A3, 0, 1, 2, A1));
    vecs.push_back(mv(0, 0, 1, 1, A3, 0, 1, 1, A2));
    vecs.push_back(mv(0, 0, 1, 1, A3, 1, 1, 1, A3));
    vecs.push_back(mv(0, 0, 0, 1, Z,  1, 0, 0, A3));
    // alternating out_ready, upstream holds until accepted
    vecs.push_back(mv(0, 0, 1, 1, C1, 1, 1, 1, C1));
    vecs.push_back(mv(0, 0, 1, 0, C2, 1, 1, 2, C1));
    vecs.push_back(mv(0, 0, 1, 1, C3, 0, 1, 1, C2));
    vecs.push_back(mv(0, 0, 1, 0, C3, 1, 1, 2, C2));
    vecs.push_back(mv(0, 0, 1, 1, C4, 0, 1, 1, C3));
    vecs.push_back(mv(0, 0, 1, 0, C4, 1, 1, 2, C3));
    vecs.push_back(mv(0, 0, 1, 1, C5, 0, 1, 1, C4));
    vecs.push_back(mv(0, 0, 0, 1, Z,  1, 0, 0, C4));
    // flush while full; FFFF must never reach the output
    vecs.push_back(mv(0, 0, 1, 0, D1, 1, 1, 1, D1));
    vecs.push_back(mv(0, 0, 1, 0, D2, 1, 1, 2, D1));
    vecs.push_back(mv(0, 1, 1, 0, E,  0, 0, 0, D1));
    vecs.push_back(mv(0, 0, 0, 1, Z,  1, 0, 0, D1));
    vecs.push_back(mv(0, 1, 1, 1, E,  0, 0, 0, D1));
    // reset while holding one bundle with sel=3
    vecs.push_back(mv(0, 0, 1, 0, F,  1, 1, 1, F));
    vecs.push_back(mv(1, 0, 1, 1, G,  1, 0, 0, Z));
    vecs.push_back(mv(0, 0, 0, 0, Z,  1, 0, 0, Z));
    // reset wins over flush and a pending accept
    vecs.push_back(mv(0, 0, 1, 0, F,  1, 1, 1, F));
    vecs.push_back(mv(1, 1, 1, 0, G,  0, 0, 0, Z));

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_d0 = '0; in_d1 = '0; in_d2 = '0; in_d3 = '0; in_sel = '0;
    flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0;
    in8_d0 = '0; in8_d1 = '0; in8_d2 = '0; in8_d3 = '0; in8_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", -1, {15'b0, out_valid}, 16'd0);
    chk("rst_occ", -1, {14'b0, occupancy}, 16'd0);
    chk("rst_d0", -1, out_d0, 16'd0);
    chk("rst_sel", -1, {14'b0, out_sel}, 16'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].rst;
      flush     = vecs[i].fl;
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      in_d0     = vecs[i].in.d0;
      in_d1     = vecs[i].in.d1;
      in_d2     = vecs[i].in.d2;
      in_d3     = vecs[i].in.d3;
      in_sel    = vecs[i].in.sel;
      #1;
      chk("in_ready", i, {15'b0, in_ready}, {15'b0, vecs[i].e_ir});
      @(posedge clk);
      #1;
      chk("out_valid", i, {15'b0, out_valid}, {15'b0, vecs[i].e_ov});
      chk("occupancy", i, {14'b0, occupancy}, {14'b0, vecs[i].e_occ});
      chk("out_d0", i, out_d0, vecs[i].ex.d0);
      chk("out_d1", i, out_d1, vecs[i].ex.d1);
      chk("out_d2", i, out_d2, vecs[i].ex.d2);
      chk("out_d3", i, out_d3, vecs[i].ex.d3);
      chk("out_sel", i, {14'b0, out_sel}, {14'b0, vecs[i].ex.sel});
    end

    // N=8 instance: all-ones operands travel unmodified
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    in8_d0 = 8'hFF; in8_d1 = 8'h00; in8_d2 = 8'hFF; in8_d3 = 8'h5A;
    in8_sel = 2'd1;
    #1;
    chk("n8_ready", 100, {15'b0, in_ready8}, 16'd1);
    @(posedge clk);
    #1;
    chk("n8_ov", 100, {15'b0, out_valid8}, 16'd1);
    chk("n8_d0", 100, {8'b0, out8_d0}, 16'h00FF);
    chk("n8_d3", 100, {8'b0, out8_d3}, 16'h005A);
    chk("n8_sel", 100, {14'b0, out8_sel}, 16'd1);
    in8_d0 = 8'h00; in8_d1 = 8'hFF; in8_d2 = 8'hA5; in8_d3 = 8'hFF;
    in8_sel = 2'd2;
    @(posedge clk);
    #1;
    chk("n8_d1", 101, {8'b0, out8_d1}, 16'h00FF);
    chk("n8_d2", 101, {8'b0, out8_d2}, 16'h00A5);
    chk("n8_d3b", 101, {8'b0, out8_d3}, 16'h00FF);
    chk("n8_selb", 101, {14'b0, out8_sel}, 16'd2);
    in_valid8 = 1'b0;
    @(posedge clk);
    #1;
    chk("n8_empty", 102, {14'b0, occupancy8}, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
